// File: rtl/tuner_phy_pkg.sv
// Shared types and helpers for the tuner PHY detect blocks.
// Holds the multi-channel detect FSM states and the clamped averaging shift.
package tuner_phy_pkg;

    typedef enum logic [1:0] {
        MC_DETECT_IDLE,
        MC_DETECT_WAIT,
        MC_DETECT_ACTIVE,
        MC_DETECT_DONE
    } tuner_phy_mc_detect_state_e;

    // Requested log2 sample count, limited to what the accumulators can hold
    function automatic int unsigned clamp_log2(
        input int unsigned req,
        input int unsigned max_l2
    );
        return (req > max_l2) ? max_l2 : req;
    endfunction

endpackage

// File: rtl/tuner_pwr_acc_ch.sv
// One ring channel accumulator with clear, enable and shift-average output.
// The average reflects the value the accumulator takes at the next edge.
module tuner_pwr_acc_ch #(
    parameter int ADC_WIDTH    = 8,
    parameter int MAX_LOG2_AVG = 4,
    parameter int SW           = 3
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [ADC_WIDTH-1:0] i_sample,
    input  logic [SW-1:0]        i_shift,
    output logic [ADC_WIDTH-1:0] o_avg
);

    localparam int AW = ADC_WIDTH + MAX_LOG2_AVG;

    logic [AW-1:0] acc_q, acc_d;

    // Next accumulator value: clear wins over accumulate
    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_q + AW'(i_sample);
        end
    end

    // Accumulator register
    always_ff @(posedge i_clk) begin
        acc_q <= acc_d;
    end

    assign o_avg = ADC_WIDTH'(acc_d >> i_shift);

endmodule

// File: rtl/tuner_pwr_detect_mc_phy.sv
// Multi-channel ring power detector: settle, average NUM_CH ADC streams, report.
// Optional TUNER_PWR_DETECT_PEAK_EN adds a peak-channel stage before DONE.
module tuner_pwr_detect_mc_phy
    import tuner_phy_pkg::*;
#(
    parameter int ADC_WIDTH    = 8,
    parameter int NUM_CH       = 4,
    parameter int WAIT_WIDTH   = 8,
    parameter int MAX_LOG2_AVG = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_CH*ADC_WIDTH-1:0]        i_dig_ring_pwr,
    input  logic                               i_read_val,
    output logic                               o_read_rdy,
    input  logic [WAIT_WIDTH-1:0]              i_read_wait,
    input  logic [$clog2(MAX_LOG2_AVG+1)-1:0]  i_read_log2_avg,
    input  logic [NUM_CH-1:0]                  i_read_ch_mask,
    input  logic                               i_abort,
    output logic                               o_detect_val,
    input  logic                               i_detect_rdy,
    output logic [NUM_CH*ADC_WIDTH-1:0]        o_detect_data,
    output logic [NUM_CH-1:0]                  o_detect_mask,
    output logic                               o_busy
`ifdef TUNER_PWR_DETECT_PEAK_EN
    ,
    output logic [$clog2(NUM_CH>1?NUM_CH:2)-1:0] o_peak_ch,
    output logic [ADC_WIDTH-1:0]               o_peak_pwr
`endif
);

    localparam int LW  = $clog2(MAX_LOG2_AVG + 1);
    localparam int CW  = MAX_LOG2_AVG + 1;
    localparam int DW  = NUM_CH * ADC_WIDTH;
    localparam int CHW = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    tuner_phy_mc_detect_state_e state_q;

    logic [WAIT_WIDTH-1:0] wait_q, wcnt_q;
    logic [LW-1:0]         l2_q, l2_d;
    logic [NUM_CH-1:0]     mask_q, dmask_q;
    logic [CW-1:0]         scnt_q;
    logic                  rdy_q, val_q, busy_q;
    logic [DW-1:0]         data_q, avg_d;
    logic                  read_fire, detect_fire, clr;
    logic                  w_last, s_last, sampling;

    assign read_fire   = i_read_val & rdy_q;
    assign detect_fire = val_q & i_detect_rdy;
    assign clr         = i_rst | read_fire;
    assign l2_d        = LW'(clamp_log2(32'(i_read_log2_avg), MAX_LOG2_AVG));
    assign w_last      = wcnt_q == wait_q - WAIT_WIDTH'(1);
    assign s_last      = scnt_q == (CW'(1) << l2_q) - CW'(1);

`ifdef TUNER_PWR_DETECT_PEAK_EN
    logic            fin_q;
    logic [DW-1:0]   res_q;
    logic [CHW-1:0]  pk_ch_d, pk_ch_q;
    logic [ADC_WIDTH-1:0] pk_pwr_d, pk_pwr_q;
    logic            pk_found;

    assign sampling = (state_q == MC_DETECT_ACTIVE) & ~fin_q;

    // Argmax of the staged averages over masked channels, lowest index on ties
    always_comb begin
        pk_ch_d  = '0;
        pk_pwr_d = '0;
        pk_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mask_q[k] &&
                (!pk_found || res_q[k*ADC_WIDTH +: ADC_WIDTH] > pk_pwr_d)) begin
                pk_found = 1'b1;
                pk_ch_d  = CHW'(k);
                pk_pwr_d = res_q[k*ADC_WIDTH +: ADC_WIDTH];
            end
        end
    end

    assign o_peak_ch  = pk_ch_q;
    assign o_peak_pwr = pk_pwr_q;
`else
    assign sampling = state_q == MC_DETECT_ACTIVE;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tuner_pwr_acc_ch #(
            .ADC_WIDTH    (ADC_WIDTH),
            .MAX_LOG2_AVG (MAX_LOG2_AVG),
            .SW           (LW)
        ) u_acc (
            .i_clk    (i_clk),
            .i_clr    (clr),
            .i_en     (sampling & mask_q[k]),
            .i_sample (i_dig_ring_pwr[k*ADC_WIDTH +: ADC_WIDTH]),
            .i_shift  (l2_q),
            .o_avg    (avg_d[k*ADC_WIDTH +: ADC_WIDTH])
        );
    end

    // Request/settle/average/report sequencer with registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MC_DETECT_IDLE;
            wait_q  <= '0;
            wcnt_q  <= '0;
            l2_q    <= '0;
            mask_q  <= '0;
            scnt_q  <= '0;
            rdy_q   <= 1'b1;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            dmask_q <= '0;
`ifdef TUNER_PWR_DETECT_PEAK_EN
            fin_q    <= 1'b0;
            res_q    <= '0;
            pk_ch_q  <= '0;
            pk_pwr_q <= '0;
`endif
        end else begin
            unique case (state_q)
                MC_DETECT_IDLE, MC_DETECT_DONE: begin
                    if (read_fire) begin
                        wait_q  <= i_read_wait;
                        l2_q    <= l2_d;
                        mask_q  <= i_read_ch_mask;
                        wcnt_q  <= '0;
                        scnt_q  <= '0;
                        rdy_q   <= 1'b0;
                        val_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        data_q  <= '0;
                        dmask_q <= '0;
`ifdef TUNER_PWR_DETECT_PEAK_EN
                        pk_ch_q  <= '0;
                        pk_pwr_q <= '0;
`endif
                        state_q <= (i_read_wait != '0) ? MC_DETECT_WAIT
                                                       : MC_DETECT_ACTIVE;
                    end else if (detect_fire) begin
                        val_q   <= 1'b0;
                        data_q  <= '0;
                        dmask_q <= '0;
`ifdef TUNER_PWR_DETECT_PEAK_EN
                        pk_ch_q  <= '0;
                        pk_pwr_q <= '0;
`endif
                        state_q <= MC_DETECT_IDLE;
                    end
                end
                MC_DETECT_WAIT: begin
                    if (i_abort) begin
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MC_DETECT_IDLE;
                    end else if (w_last) begin
                        state_q <= MC_DETECT_ACTIVE;
                    end else begin
                        wcnt_q <= wcnt_q + WAIT_WIDTH'(1);
                    end
                end
                MC_DETECT_ACTIVE: begin
                    if (i_abort) begin
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef TUNER_PWR_DETECT_PEAK_EN
                        fin_q   <= 1'b0;
`endif
                        state_q <= MC_DETECT_IDLE;
`ifdef TUNER_PWR_DETECT_PEAK_EN
                    end else if (fin_q) begin
                        fin_q    <= 1'b0;
                        data_q   <= res_q;
                        pk_ch_q  <= pk_ch_d;
                        pk_pwr_q <= pk_pwr_d;
                        dmask_q  <= mask_q;
                        val_q    <= 1'b1;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= MC_DETECT_DONE;
                    end else if (s_last) begin
                        fin_q <= 1'b1;
                        res_q <= avg_d;
`else
                    end else if (s_last) begin
                        data_q  <= avg_d;
                        dmask_q <= mask_q;
                        val_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MC_DETECT_DONE;
`endif
                    end else begin
                        scnt_q <= scnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_read_rdy    = rdy_q;
    assign o_detect_val  = val_q;
    assign o_detect_data = data_q;
    assign o_detect_mask = dmask_q;
    assign o_busy        = busy_q;

endmodule
